// File: rtl/riscv_cache_mem_arbiter_pkg.sv
// Shared constants and sizing helpers for the cache-side memory arbiter.
package riscv_cache_mem_arbiter_pkg;

    // Arbitration modes
    localparam int ARB_RR    = 0;   // rotating priority, pointer moves past each winner
    localparam int ARB_FIXED = 1;   // port 0 always highest

    // Memory request message layout: {type, addr, len, data}
    function automatic int req_msg_sz(input int addr_sz, input int data_sz);
        return 1 + addr_sz + $clog2(data_sz / 8) + data_sz;
    endfunction

    // Memory response message layout: {type, len, data}
    function automatic int resp_msg_sz(input int data_sz);
        return 1 + $clog2(data_sz / 8) + data_sz;
    endfunction

    // Port-index width; kept at least one bit so single-port builds still carry a route tag.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riscv_cache_arb_route_fifo.sv
// Route FIFO: remembers which cache port owns each outstanding memory request so the
// in-order memory responses can be steered back. Depth must be a power of two.
module riscv_cache_arb_route_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH; occupancy tracks push/pop difference.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset; it is only read while occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/riscv_cache_mem_arbiter.sv
// N-port memory-side arbiter: merges per-cache request streams onto one memory port and
// steers in-order memory responses back to the issuing cache via a route FIFO.
module riscv_cache_mem_arbiter
    import riscv_cache_mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_SZ   = 32,
    parameter int DATA_SZ   = 32,
    parameter int MAX_OUTS  = 4,
    parameter int ARB_MODE  = ARB_RR,
    localparam int RQ = req_msg_sz(ADDR_SZ, DATA_SZ),
    localparam int RS = resp_msg_sz(DATA_SZ),
    localparam int IW = idx_w(NUM_PORTS),
    localparam int CW = $clog2(MAX_OUTS) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    cachereq_val,
    output logic [NUM_PORTS-1:0]    cachereq_rdy,
    input  logic [NUM_PORTS*RQ-1:0] cachereq_msg,
    output logic [NUM_PORTS-1:0]    cacheresp_val,
    input  logic [NUM_PORTS-1:0]    cacheresp_rdy,
    output logic [NUM_PORTS*RS-1:0] cacheresp_msg,
    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic [RQ-1:0]           memreq_msg,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [RS-1:0]           memresp_msg,
    output logic [CW-1:0]           outs_cnt
);

    logic [RQ-1:0]        req_slice [NUM_PORTS];
    logic [NUM_PORTS-1:0] hi_mask;
    logic [NUM_PORTS-1:0] hi_req;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        arb_idx;
    logic [IW-1:0]        win;
    logic [IW-1:0]        lock_idx;
    logic [IW-1:0]        head;
    logic                 lock_vld;
    logic                 any_val;
    logic                 can_issue;
    logic                 req_fire;
    logic                 resp_fire;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Per-port request slices; the response word is broadcast to every port slice.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign req_slice[g]                 = cachereq_msg[g*RQ +: RQ];
        assign cacheresp_msg[g*RS +: RS]    = memresp_msg;
    end

    // Lowest-index set bit of a request vector.
    function automatic logic [IW-1:0] lowest_set(input logic [NUM_PORTS-1:0] v);
        lowest_set = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IW'(i);
        end
    endfunction

    // Ports at or after the rotating pointer get first pick.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            hi_mask[i] = (IW'(i) >= rr_ptr);
        end
    end

    assign hi_req = cachereq_val & hi_mask;

    // Raw winner: round-robin wraps to the lowest index when nothing sits at/after the pointer.
    always_comb begin
        if (ARB_MODE == ARB_FIXED || hi_req == '0) arb_idx = lowest_set(cachereq_val);
        else                                       arb_idx = lowest_set(hi_req);
    end

    // A stalled grant stays with its port until the memory side accepts it.
    assign win       = (lock_vld && cachereq_val[lock_idx]) ? lock_idx : arb_idx;
    assign any_val   = |cachereq_val;
    assign can_issue = memreq_rdy & ~fifo_full;

    assign memreq_val = reset & any_val & ~fifo_full;
    assign memreq_msg = req_slice[win];
    assign req_fire   = memreq_val & memreq_rdy;

    // Only the winning port sees ready; nothing is ready when no port is requesting.
    always_comb begin
        cachereq_rdy = '0;
        if (reset && any_val && can_issue) cachereq_rdy[win] = 1'b1;
    end

    // Responses go to the FIFO head only; a stalled head blocks every other port.
    always_comb begin
        cacheresp_val = '0;
        if (reset && memresp_val && !fifo_empty) cacheresp_val[head] = 1'b1;
    end

    assign memresp_rdy = reset & ~fifo_empty & cacheresp_rdy[head];
    assign resp_fire   = memresp_val & memresp_rdy;

    // Capture the grant whenever the memory side stalls a presented request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else if (memreq_val && !memreq_rdy) begin
            lock_vld <= 1'b1;
            lock_idx <= win;
        end else begin
            lock_vld <= 1'b0;
        end
    end

    // Rotate the priority pointer past each accepted winner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (req_fire && ARB_MODE == ARB_RR) begin
            rr_ptr <= (win == IW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
        end
    end

    riscv_cache_arb_route_fifo #(
        .DEPTH (MAX_OUTS),
        .WIDTH (IW)
    ) u_route_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_fire),
        .push_data (win),
        .pop       (resp_fire),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outs_cnt)
    );

    // A memory response with nothing outstanding has no owner and is never accepted.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!reset)
        !(memresp_val && fifo_empty));

endmodule

// File: tb/tb_riscv_cache_mem_arbiter.sv
module tb_riscv_cache_mem_arbiter;
    import riscv_cache_mem_arbiter_pkg::*;

    localparam int RQ = req_msg_sz(32, 32);
    localparam int RS = resp_msg_sz(32);
    localparam int NA = 2;
    localparam int NB = 4;
    localparam int MO = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 2 ports, round-robin
    logic             reset_a;
    logic [NA-1:0]    creq_val_a, creq_rdy_a, cresp_val_a, cresp_rdy_a;
    logic [NA*RQ-1:0] creq_msg_a;
    logic [NA*RS-1:0] cresp_msg_a;
    logic             mreq_val_a, mreq_rdy_a, mresp_val_a, mresp_rdy_a;
    logic [RQ-1:0]    mreq_msg_a;
    logic [RS-1:0]    mresp_msg_a;
    logic [CW-1:0]    cnt_a;

    // DUT B: 4 ports, fixed priority
    logic             reset_b;
    logic [NB-1:0]    creq_val_b, creq_rdy_b, cresp_val_b, cresp_rdy_b;
    logic [NB*RQ-1:0] creq_msg_b;
    logic [NB*RS-1:0] cresp_msg_b;
    logic             mreq_val_b, mreq_rdy_b, mresp_val_b, mresp_rdy_b;
    logic [RQ-1:0]    mreq_msg_b;
    logic [RS-1:0]    mresp_msg_b;
    logic [CW-1:0]    cnt_b;

    riscv_cache_mem_arbiter #(.NUM_PORTS(NA), .ADDR_SZ(32), .DATA_SZ(32), .MAX_OUTS(MO),
                              .ARB_MODE(ARB_RR)) dut_a (
        .clk(clk), .reset(reset_a),
        .cachereq_val(creq_val_a), .cachereq_rdy(creq_rdy_a), .cachereq_msg(creq_msg_a),
        .cacheresp_val(cresp_val_a), .cacheresp_rdy(cresp_rdy_a), .cacheresp_msg(cresp_msg_a),
        .memreq_val(mreq_val_a), .memreq_rdy(mreq_rdy_a), .memreq_msg(mreq_msg_a),
        .memresp_val(mresp_val_a), .memresp_rdy(mresp_rdy_a), .memresp_msg(mresp_msg_a),
        .outs_cnt(cnt_a));

    riscv_cache_mem_arbiter #(.NUM_PORTS(NB), .ADDR_SZ(32), .DATA_SZ(32), .MAX_OUTS(MO),
                              .ARB_MODE(ARB_FIXED)) dut_b (
        .clk(clk), .reset(reset_b),
        .cachereq_val(creq_val_b), .cachereq_rdy(creq_rdy_b), .cachereq_msg(creq_msg_b),
        .cacheresp_val(cresp_val_b), .cacheresp_rdy(cresp_rdy_b), .cacheresp_msg(cresp_msg_b),
        .memreq_val(mreq_val_b), .memreq_rdy(mreq_rdy_b), .memreq_msg(mreq_msg_b),
        .memresp_val(mresp_val_b), .memresp_rdy(mresp_rdy_b), .memresp_msg(mresp_msg_b),
        .outs_cnt(cnt_b));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [RQ-1:0] msg_a [NA];
    logic [RQ-1:0] msg_b [NB];

    task automatic drive_msgs();
        for (int p = 0; p < NA; p++) creq_msg_a[p*RQ +: RQ] = msg_a[p];
        for (int p = 0; p < NB; p++) creq_msg_b[p*RQ +: RQ] = msg_b[p];
    endtask

    typedef struct {
        logic [1:0] val;
        logic       mrdy;
        logic       mrval;
        logic [1:0] crdy;
        int         gnt;
        logic [1:0] x_creq_rdy;
        logic       x_mreq_val;
        logic [1:0] x_cresp_val;
        logic       x_mresp_rdy;
        logic [2:0] x_cnt;
    } vec_t;

    vec_t tv [8];

    // Model state
    int   q[$];
    int   qb[$];
    int   rr, lock_w, w, hd;
    bit   lock;
    logic [NA-1:0] pend, xc2, xr2;
    logic [NB-1:0] xc4;
    logic full, any, xmval, xmrrdy;

    initial begin
        #300000;
        $display("FAIL watchdog: run did not end, time %0t", $time);
        $fatal(1);
    end

    initial begin
        // Both ports always valid, memory always ready, one response per cycle after the first.
        tv[0] = '{2'b11, 1'b1, 1'b0, 2'b11, 0, 2'b01, 1'b1, 2'b00, 1'b0, 3'd0};
        tv[1] = '{2'b11, 1'b1, 1'b1, 2'b11, 1, 2'b10, 1'b1, 2'b01, 1'b1, 3'd1};
        tv[2] = '{2'b11, 1'b1, 1'b1, 2'b11, 0, 2'b01, 1'b1, 2'b10, 1'b1, 3'd1};
        tv[3] = '{2'b11, 1'b1, 1'b1, 2'b11, 1, 2'b10, 1'b1, 2'b01, 1'b1, 3'd1};
        tv[4] = '{2'b11, 1'b1, 1'b1, 2'b11, 0, 2'b01, 1'b1, 2'b10, 1'b1, 3'd1};
        tv[5] = '{2'b11, 1'b1, 1'b1, 2'b11, 1, 2'b10, 1'b1, 2'b01, 1'b1, 3'd1};
        tv[6] = '{2'b11, 1'b1, 1'b1, 2'b11, 0, 2'b01, 1'b1, 2'b10, 1'b1, 3'd1};
        tv[7] = '{2'b11, 1'b1, 1'b1, 2'b11, 1, 2'b10, 1'b1, 2'b01, 1'b1, 3'd1};

        msg_a[0] = RQ'(128'h1_0000_1000_3_AAAA_0000);
        msg_a[1] = RQ'(128'h0_0000_2000_1_BBBB_1111);
        for (int p = 0; p < NB; p++) msg_b[p] = RQ'({$urandom, $urandom, $urandom});
        drive_msgs();

        // ---- reset held with every input asserted ----
        reset_a = 1'b0; reset_b = 1'b0;
        creq_val_a = '1; mreq_rdy_a = 1'b1; mresp_val_a = 1'b1; cresp_rdy_a = '1; mresp_msg_a = '0;
        creq_val_b = '1; mreq_rdy_b = 1'b1; mresp_val_b = 1'b1; cresp_rdy_b = '1; mresp_msg_b = '0;
        tick(); tick();
        #1;
        chk("rst creq_rdy", creq_rdy_a, 0);
        chk("rst memreq_val", mreq_val_a, 0);
        chk("rst cresp_val", cresp_val_a, 0);
        chk("rst memresp_rdy", mresp_rdy_a, 0);
        chk("rst outs_cnt", cnt_a, 0);
        chk("rstB creq_rdy", creq_rdy_b, 0);
        chk("rstB memreq_val", mreq_val_b, 0);
        mresp_val_a = 1'b0; mresp_val_b = 1'b0; creq_val_b = '0;
        reset_a = 1'b1; reset_b = 1'b1;

        // ---- RR fairness table (row 0 is the first grant after reset) ----
        for (int k = 0; k < 8; k++) begin
            creq_val_a = tv[k].val; mreq_rdy_a = tv[k].mrdy; mresp_val_a = tv[k].mrval;
            cresp_rdy_a = tv[k].crdy; mresp_msg_a = RS'(32'hA0 + k);
            #1;
            chk($sformatf("rr%0d creq_rdy", k), creq_rdy_a, tv[k].x_creq_rdy);
            chk($sformatf("rr%0d memreq_val", k), mreq_val_a, tv[k].x_mreq_val);
            chk($sformatf("rr%0d memreq_msg", k), mreq_msg_a, msg_a[tv[k].gnt]);
            chk($sformatf("rr%0d cresp_val", k), cresp_val_a, tv[k].x_cresp_val);
            chk($sformatf("rr%0d memresp_rdy", k), mresp_rdy_a, tv[k].x_mresp_rdy);
            chk($sformatf("rr%0d outs_cnt", k), cnt_a, tv[k].x_cnt);
            if (tv[k].mrval) chk($sformatf("rr%0d resp_msg", k), cresp_msg_a, {NA{RS'(32'hA0 + k)}});
            tick();
        end
        // drain the last (port 1) response
        creq_val_a = '0; mresp_val_a = 1'b1; cresp_rdy_a = '1; mresp_msg_a = RS'(32'hA8);
        #1;
        chk("drain cresp_val", cresp_val_a, 2'b10);
        chk("drain memresp_rdy", mresp_rdy_a, 1);
        tick();
        mresp_val_a = 1'b0;
        #1;
        chk("drain outs_cnt", cnt_a, 0);

        // ---- lock: port1 stalled, port0 joins mid-stall (pointer now at 0) ----
        for (int k = 0; k < 5; k++) begin
            creq_val_a = (k == 0) ? 2'b10 : (k == 4) ? 2'b01 : 2'b11;
            mreq_rdy_a = (k >= 3);
            #1;
            chk($sformatf("lock%0d memreq_val", k), mreq_val_a, 1);
            chk($sformatf("lock%0d memreq_msg", k), mreq_msg_a, msg_a[(k == 4) ? 0 : 1]);
            chk($sformatf("lock%0d creq_rdy", k), creq_rdy_a,
                (k < 3) ? 2'b00 : (k == 3) ? 2'b10 : 2'b01);
            tick();
        end
        creq_val_a = '0;
        #1;
        chk("lock outs_cnt", cnt_a, 2);

        // ---- head-of-line: queue holds ports 1,0; port 1 stalls 4 cycles ----
        mresp_val_a = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cresp_rdy_a = (k < 4) ? 2'b01 : 2'b11;
            mresp_msg_a = RS'(32'hC0 + k);
            #1;
            chk($sformatf("hol%0d memresp_rdy", k), mresp_rdy_a, (k >= 4));
            chk($sformatf("hol%0d cresp_val", k), cresp_val_a, (k == 5) ? 2'b01 : 2'b10);
            tick();
        end
        mresp_val_a = 1'b0;
        #1;
        chk("hol outs_cnt", cnt_a, 0);

        // ---- full: 5 requests, 4 accepted; response on the 5th cycle frees a slot next cycle ----
        creq_val_a = 2'b01; mreq_rdy_a = 1'b1; cresp_rdy_a = '1;
        for (int k = 0; k < 6; k++) begin
            mresp_val_a = (k == 4);
            #1;
            chk($sformatf("full%0d outs_cnt", k), cnt_a, (k < 4) ? k : (k == 4) ? 4 : 3);
            chk($sformatf("full%0d memreq_val", k), mreq_val_a, (k != 4));
            chk($sformatf("full%0d creq_rdy", k), creq_rdy_a, (k != 4) ? 2'b01 : 2'b00);
            if (k == 4) chk("full4 memresp_rdy", mresp_rdy_a, 1);
            tick();
        end
        creq_val_a = '0; mresp_val_a = 1'b1;
        repeat (4) tick();
        mresp_val_a = 1'b0;
        #1;
        chk("full drain outs_cnt", cnt_a, 0);

        // ---- randomized RR traffic against the queue model ----
        reset_a = 1'b0;
        #1;
        reset_a = 1'b1;
        tick();
        q.delete(); rr = 0; lock = 0; lock_w = 0; pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NA; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    pend[p] = 1'b1;
                    msg_a[p] = RQ'({$urandom, $urandom, $urandom});
                end
            end
            drive_msgs();
            creq_val_a  = pend;
            mreq_rdy_a  = ($urandom_range(0, 3) != 0);
            mresp_val_a = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            cresp_rdy_a = NA'($urandom);
            mresp_msg_a = RS'({$urandom, $urandom});
            #1;
            full = (q.size() == MO);
            any  = |pend;
            w = -1;
            if (any) begin
                if (lock && pend[lock_w]) w = lock_w;
                else begin
                    for (int k = 0; k < NA; k++) begin
                        if (pend[(rr + k) % NA]) begin w = (rr + k) % NA; break; end
                    end
                end
            end
            xmval = any && !full;
            xc2 = '0;
            if (xmval && mreq_rdy_a) xc2[w] = 1'b1;
            hd = (q.size() > 0) ? q[0] : -1;
            xr2 = '0;
            if (hd >= 0 && mresp_val_a) xr2[hd] = 1'b1;
            xmrrdy = (hd >= 0) && cresp_rdy_a[hd];
            chk("rnd memreq_val", mreq_val_a, xmval);
            chk("rnd creq_rdy", creq_rdy_a, xc2);
            if (xmval) chk("rnd memreq_msg", mreq_msg_a, msg_a[w]);
            chk("rnd cresp_val", cresp_val_a, xr2);
            chk("rnd memresp_rdy", mresp_rdy_a, xmrrdy);
            chk("rnd outs_cnt", cnt_a, q.size());
            if (mresp_val_a && xmrrdy) void'(q.pop_front());
            if (xmval && mreq_rdy_a) begin
                q.push_back(w);
                rr = (w + 1) % NA;
                pend[w] = 1'b0;
            end
            lock   = xmval && !mreq_rdy_a;
            lock_w = w;
            tick();
        end
        creq_val_a = '0; mresp_val_a = 1'b0;

        // ---- fixed priority, 4 ports, random requests ----
        qb.delete();
        for (int c = 0; c < 40; c++) begin
            creq_val_b  = NB'($urandom);
            mreq_rdy_b  = 1'b1;
            mresp_val_b = (qb.size() > 0) && ($urandom_range(0, 1) == 1);
            cresp_rdy_b = '1;
            #1;
            w = -1;
            for (int p = NB - 1; p >= 0; p--) if (creq_val_b[p]) w = p;
            full = (qb.size() == MO);
            xc4 = '0;
            if (w >= 0 && !full) xc4[w] = 1'b1;
            chk("fp creq_rdy", creq_rdy_b, xc4);
            if (w >= 0 && !full) chk("fp memreq_msg", mreq_msg_b, msg_b[w]);
            chk("fp memresp_rdy", mresp_rdy_b, (qb.size() > 0));
            chk("fp outs_cnt", cnt_b, qb.size());
            if (mresp_val_b && qb.size() > 0) void'(qb.pop_front());
            if (w >= 0 && !full) qb.push_back(w);
            tick();
        end

        // ports 1 and 3 always valid, no responses: port 3 never wins
        creq_val_b = 4'b1010; mresp_val_b = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("fp13 port3 rdy", creq_rdy_b[3], 0);
            chk("fp13 creq_rdy", creq_rdy_b, (qb.size() < MO) ? 4'b0010 : 4'b0000);
            if (qb.size() < MO) qb.push_back(1);
            tick();
        end
        chk("fp13 outs_cnt full", cnt_b, 4);

        // mid-cycle async reset: everything clears immediately
        #2;
        reset_b = 1'b0;
        #1;
        chk("arst outs_cnt", cnt_b, 0);
        chk("arst memreq_val", mreq_val_b, 0);
        chk("arst creq_rdy", creq_rdy_b, 0);
        chk("arst memresp_rdy", mresp_rdy_b, 0);
        reset_b = 1'b1;
        qb.delete();
        #1;
        chk("arst release creq_rdy", creq_rdy_b, 4'b0010);
        chk("arst release outs_cnt", cnt_b, 0);
        tick();
        creq_val_b = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
